// File: rtl/jk_bank_ctrl_if.sv
// Command channel between a command master and the JK bank controller.
interface jk_bank_ctrl_if #(
    parameter int N  = 4,
    parameter int CW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [N-1:0]  cmd_data;
    logic [CW-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Command-driven sequencer for a bank of N JK flip-flops. Each accepted
// command becomes per-bit j/k drive for one or more cycles; the bank applies
// ns = (j & ~q) | (~k & q) on every edge, holding whenever j = k = 0.
module jk_bank_ctrl #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    jk_bank_ctrl_if.slave cmd,
    output logic [N-1:0] q,
    output logic [N-1:0] j,
    output logic [N-1:0] k,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_SET  = 3'd1,
        OP_CLR  = 3'd2,
        OP_TOG  = 3'd3,
        OP_LOAD = 3'd4,
        OP_UP   = 3'd5,
        OP_DN   = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    state_t        state;
    state_t        state_next;
    op_t           op_q;
    logic [N-1:0]  data_q;
    logic [CW-1:0] cnt_q;
    logic          ready_en;
    logic          cmd_ready_int;
    logic          accept;
    logic          accept_is_cnt;
    logic          exec_is_cnt;

    // cmd_ready stays low through reset and rises one cycle after release,
    // so ready_en gates the IDLE decode; both are registers.
    assign cmd_ready_int = ready_en && (state == IDLE);
    assign cmd.cmd_ready = cmd_ready_int;
    assign busy          = (state == EXEC);
    assign done          = (state == DONE);

    assign accept        = cmd.cmd_valid && cmd_ready_int;
    assign accept_is_cnt = (op_t'(cmd.cmd_op) == OP_UP) || (op_t'(cmd.cmd_op) == OP_DN);
    assign exec_is_cnt   = (op_q == OP_UP) || (op_q == OP_DN);

    // State register plus the post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
        end
    end

    // Next-state: zero-length counts go straight to DONE; counts leave EXEC
    // on their last step, every other op after a single EXEC cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (accept_is_cnt && (cmd.cmd_count == '0)) begin
                        state_next = DONE;
                    end else begin
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                if (!exec_is_cnt || (cnt_q == CW'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch and step down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_NOP;
            data_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            op_q   <= op_t'(cmd.cmd_op);
            data_q <= cmd.cmd_data;
            cnt_q  <= cmd.cmd_count;
        end else if ((state == EXEC) && exec_is_cnt) begin
            cnt_q  <= cnt_q - CW'(1);
        end
    end

    // Per-bit drive. Counting toggles bit i when all lower bits are 1 (up)
    // or all lower bits are 0 (down); a running AND carries that term.
    always_comb begin
        logic run_up;
        logic run_dn;
        j      = '0;
        k      = '0;
        run_up = 1'b1;
        run_dn = 1'b1;
        if (state == EXEC) begin
            case (op_q)
                OP_SET: begin
                    j = data_q;
                end
                OP_CLR: begin
                    k = data_q;
                end
                OP_TOG: begin
                    j = data_q;
                    k = data_q;
                end
                OP_LOAD: begin
                    j = data_q;
                    k = ~data_q;
                end
                OP_UP: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        j[i]   = run_up;
                        k[i]   = run_up;
                        run_up = run_up & q[i];
                    end
                end
                OP_DN: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        j[i]   = run_dn;
                        k[i]   = run_dn;
                        run_dn = run_dn & ~q[i];
                    end
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

    // JK bank: standard JK next-state on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed and randomized checks of jk_bank_ctrl against an arithmetic model.
module tb_jk_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] q, j, k;
    logic       busy, done;
    logic [3:0] mq;
    int         total = 0;
    int         bad = 0;

    jk_bank_ctrl_if #(.N(4), .CW(8)) bus ();

    jk_bank_ctrl #(.N(4), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (bus.slave),
        .q     (q),
        .j     (j),
        .k     (k),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what one application of the op does to the register value.
    function automatic logic [3:0] mstep(input logic [2:0] op, input logic [3:0] qv,
                                         input logic [3:0] d);
        case (op)
            3'd1: return qv | d;
            3'd2: return qv & ~d;
            3'd3: return qv ^ d;
            3'd4: return d;
            3'd5: return qv + 4'd1;
            3'd6: return qv - 4'd1;
            default: return qv;
        endcase
    endfunction

    // Expected drive for one EXEC cycle starting from qv.
    task automatic exp_jk(input logic [2:0] op, input logic [3:0] qv, input logic [3:0] d,
                          output logic [3:0] ej, output logic [3:0] ek);
        case (op)
            3'd1: begin ej = d;  ek = 4'd0; end
            3'd2: begin ej = 4'd0; ek = d; end
            3'd3: begin ej = d;  ek = d; end
            3'd4: begin ej = d;  ek = ~d; end
            3'd5, 3'd6: begin ej = qv ^ mstep(op, qv, d); ek = ej; end
            default: begin ej = 4'd0; ek = 4'd0; end
        endcase
    endtask

    // Wait (bounded) for ready, present the command, return after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [7:0] c);
        int waited = 0;
        while (!bus.cmd_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.cmd_count = c;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Full command: issue, then check every EXEC cycle, the done pulse and ready return.
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] d, input logic [7:0] c);
        int steps;
        logic [3:0] ej, ek;
        steps = (op == 3'd5 || op == 3'd6) ? int'(c) : 1;
        issue(op, d, c);
        for (int s = 0; s < steps; s++) begin
            exp_jk(op, mq, d, ej, ek);
            chk("exec_busy", {31'd0, busy}, 32'd1);
            chk("exec_ready", {31'd0, bus.cmd_ready}, 32'd0);
            chk("exec_done", {31'd0, done}, 32'd0);
            chk("exec_j", {28'd0, j}, {28'd0, ej});
            chk("exec_k", {28'd0, k}, {28'd0, ek});
            tick();
            mq = mstep(op, mq, d);
            chk("q_step", {28'd0, q}, {28'd0, mq});
        end
        chk("done_hi", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("done_jk", {24'd0, j, k}, 32'd0);
        chk("done_q", {28'd0, q}, {28'd0, mq});
        tick();
        chk("done_lo", {31'd0, done}, 32'd0);
        chk("ready_back", {31'd0, bus.cmd_ready}, 32'd1);
        chk("idle_q", {28'd0, q}, {28'd0, mq});
    endtask

    initial begin
        logic [2:0] hop;
        logic       was_ready;
        logic [2:0] rop;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 4'd0;
        bus.cmd_count = 8'd0;
        mq = 4'd0;

        // Reset state
        #2;
        chk("rst_q", {28'd0, q}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("rst_jk", {24'd0, j, k}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_ready_lo", {31'd0, bus.cmd_ready}, 32'd0);
        tick();
        chk("rel_ready_hi", {31'd0, bus.cmd_ready}, 32'd1);

        // Directed single-cycle ops
        do_cmd(3'd4, 4'b1010, 8'd0);
        chk("load_val", {28'd0, q}, 32'hA);
        do_cmd(3'd1, 4'b0101, 8'd0);
        chk("set_val", {28'd0, q}, 32'hF);
        do_cmd(3'd2, 4'b0011, 8'd0);
        chk("clr_val", {28'd0, q}, 32'hC);
        do_cmd(3'd3, 4'b1001, 8'd0);
        chk("tog_val", {28'd0, q}, 32'h5);

        // Counting with wrap, and zero-length count
        do_cmd(3'd4, 4'b1110, 8'd0);
        do_cmd(3'd5, 4'd0, 8'd3);
        chk("up_wrap", {28'd0, q}, 32'h1);
        do_cmd(3'd4, 4'b0001, 8'd0);
        do_cmd(3'd6, 4'd0, 8'd2);
        chk("dn_wrap", {28'd0, q}, 32'hF);
        do_cmd(3'd5, 4'd0, 8'd0);
        chk("cnt0_hold", {28'd0, q}, 32'hF);

        // cmd_valid held high: TOG 0001 alternating with op 7
        hop = 3'd3;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = hop;
        bus.cmd_data  = 4'b0001;
        bus.cmd_count = 8'd0;
        for (int i = 0; i < 12; i++) begin
            chk("hold_ready", {31'd0, bus.cmd_ready}, {31'd0, (i % 3) == 0});
            was_ready = bus.cmd_ready;
            tick();
            if ((i % 3) == 1) begin
                mq = mstep(hop == 3'd3 ? 3'd7 : 3'd3, mq, 4'b0001);
            end
            chk("hold_done", {31'd0, done}, {31'd0, (i % 3) == 1});
            chk("hold_q", {28'd0, q}, {28'd0, mq});
            if (was_ready) begin
                hop = (hop == 3'd3) ? 3'd7 : 3'd3;
                bus.cmd_op = hop;
            end
        end
        bus.cmd_valid = 1'b0;

        // Reset in the middle of a long count
        do_cmd(3'd4, 4'd0, 8'd0);
        issue(3'd5, 4'd0, 8'd200);
        for (int s = 0; s < 5; s++) begin
            tick();
            mq = mq + 4'd1;
            chk("abort_step", {28'd0, q}, {28'd0, mq});
        end
        chk("abort_pre", {28'd0, q}, 32'h5);
        rst_n = 1'b0;
        #1;
        mq = 4'd0;
        chk("abort_q", {28'd0, q}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        tick();
        chk("abort_nodone", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_rel_lo", {31'd0, bus.cmd_ready}, 32'd0);
        chk("abort_rel_done", {31'd0, done}, 32'd0);
        tick();
        chk("abort_rel_hi", {31'd0, bus.cmd_ready}, 32'd1);
        chk("abort_rel_q", {28'd0, q}, 32'd0);

        // Randomized commands against the model
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            do_cmd(rop, 4'($urandom), 8'($urandom_range(0, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
